ps2_kbd_ctrl: RTL and testbench

Scan-code controller that sits between the PS/2 byte receiver and keyboard consumers (LCD/UART/game logic). It gates the receiver with rx_en and parses the Set-2 prefix bytes (E0 extended, F0 break) into single key events. Events are buffered in a small FWFT FIFO with a valid/ready handshake. It also detects protocol errors, prefix timeouts and FIFO overflow.

---
 rtl/ps2_kbd_ctrl.sv | 157 +++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 Set-2 scan-code controller: folds E0/F0 prefixes into single key events,
// buffers them in a first-word-fall-through FIFO and flags protocol errors and overflow.
module ps2_kbd_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_done_tick,
    input  logic [7:0]                    rx_data,
    output logic                          rx_en,
    output logic                          key_valid,
    input  logic                          key_ready,
    output logic [7:0]                    key_code,
    output logic                          key_ext,
    output logic                          key_break,
    output logic                          err_tick,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXTBRK
    } state_t;

    state_t             state, state_next;
    logic [TMO_W-1:0]   tmo_cnt, tmo_next;
    logic               push_req;
    logic [9:0]         push_data;
    logic               err_next;

    logic is_e0, is_f0, is_bad;
    assign is_e0  = (rx_data == 8'hE0);
    assign is_f0  = (rx_data == 8'hF0);
    assign is_bad = (rx_data == 8'h00) || (rx_data == 8'hFF);

    // ---------------- prefix parser ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            tmo_cnt  <= '0;
            err_tick <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state    <= state_next;
            tmo_cnt  <= tmo_next;
            err_tick <= err_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        tmo_next   = '0;
        push_req   = 1'b0;
        push_data  = {2'b00, rx_data};
        err_next   = 1'b0;

        if (rx_done_tick) begin
            case (state)
                S_IDLE: begin
                    if (is_e0)       state_next = S_EXT;
                    else if (is_f0)  state_next = S_BRK;
                    else if (is_bad) err_next   = 1'b1;
                    else             push_req   = 1'b1;
                end
                S_EXT: begin
                    if (is_f0) begin
                        state_next = S_EXTBRK;
                    end else if (is_e0) begin
                        state_next = S_EXT;
                    end else if (is_bad) begin
                        state_next = S_IDLE;
                        err_next   = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                        push_req   = 1'b1;
                        push_data  = {2'b10, rx_data};
                    end
                end
                S_BRK, S_EXTBRK: begin
                    state_next = S_IDLE;
                    if (is_e0 || is_f0 || is_bad) begin
                        err_next = 1'b1;
                    end else begin
                        push_req  = 1'b1;
                        push_data = {(state == S_EXTBRK), 1'b1, rx_data};
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end else if (state != S_IDLE) begin
            // A prefix whose completing byte never arrives is abandoned.
            if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                state_next = S_IDLE;
                err_next   = 1'b1;
            end else begin
                tmo_next = tmo_cnt + TMO_W'(1);
            end
        end
    end

    // ---------------- event FIFO ----------------
    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, pop, do_push, drop;
    logic [9:0]       head;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign pop     = key_valid & key_ready;
    assign do_push = push_req & (~full | pop);
    assign drop    = push_req & full & ~pop;

    // NOTE: storage is deliberately not reset; count gates every read, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    assign head       = mem[rd_ptr];
    assign key_valid  = (count != '0);
    assign key_code   = key_valid ? head[7:0] : 8'h00;
    assign key_break  = key_valid & head[8];
    assign key_ext    = key_valid & head[9];
    assign fifo_count = count;
    // One slot stays free for a frame already in flight when the gate closes.
    assign rx_en      = (count < CNT_W'(FIFO_DEPTH - 1));

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: directed scenarios plus random traffic,
// every cycle compared against a prefix-flag / queue reference model.
module tb_ps2_kbd_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       key_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       rx_en, key_valid, key_ext, key_break, err_tick, overflow;
    logic [7:0] key_code;
    logic [$clog2(DEPTH):0] fifo_count;

    ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rx_en        (rx_en),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_break    (key_break),
        .err_tick     (err_tick),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: pending-prefix flags, event queue, sticky overflow,
    // and the edge number of the most recent received byte for the timeout.
    logic [9:0] mq[$];
    bit         m_ext, m_brk, m_ovf, m_err;
    int         edge_n, last_tick;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic void model_edge(input bit rst, input bit tick, input logic [7:0] b,
                                       input bit rdy, input bit clr);
        bit         push, pop, err;
        logic [9:0] ev;
        push = 1'b0;
        err  = 1'b0;
        ev   = '0;
        edge_n++;
        if (rst) begin
            mq.delete();
            m_ext = 0; m_brk = 0; m_ovf = 0; m_err = 0;
            last_tick = edge_n;
            return;
        end
        if (tick) begin
            last_tick = edge_n;
            if (b == 8'h00 || b == 8'hFF) begin
                err = 1; m_ext = 0; m_brk = 0;
            end else if (b == 8'hE0 || b == 8'hF0) begin
                // A prefix after F0 is illegal; repeated E0 is tolerated.
                if (m_brk) begin
                    err = 1; m_ext = 0; m_brk = 0;
                end else if (b == 8'hE0) m_ext = 1;
                else m_brk = 1;
            end else begin
                push = 1; ev = {m_ext, m_brk, b}; m_ext = 0; m_brk = 0;
            end
        end else if ((m_ext || m_brk) && (edge_n - last_tick == TMO)) begin
            err = 1; m_ext = 0; m_brk = 0;
        end
        pop = (mq.size() != 0) && rdy;
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(ev);
            else m_ovf = 1;
        end else if (clr) m_ovf = 0;
        if (push && clr && mq.size() < DEPTH) m_ovf = 0;
        m_err = err;
    endfunction

    task automatic compare_all();
        logic [9:0] h;
        h = (mq.size() != 0) ? mq[0] : 10'h000;
        check("key_valid",  32'(key_valid),  32'(mq.size() != 0));
        check("key_code",   32'(key_code),   32'(h[7:0]));
        check("key_ext",    32'(key_ext),    32'(h[9]));
        check("key_break",  32'(key_break),  32'(h[8]));
        check("fifo_count", 32'(fifo_count), 32'(mq.size()));
        check("rx_en",      32'(rx_en),      32'(mq.size() < DEPTH - 1));
        check("err_tick",   32'(err_tick),   32'(m_err));
        check("overflow",   32'(overflow),   32'(m_ovf));
    endtask

    // Drive one cycle of inputs (we are #1 after an edge), take the edge, then compare.
    task automatic cycle(input bit rst, input bit tick, input logic [7:0] b,
                         input bit rdy, input bit clr);
        reset = rst; rx_done_tick = tick; rx_data = b; key_ready = rdy; ovf_clr = clr;
        @(posedge clk);
        model_edge(rst, tick, b, rdy, clr);
        #1;
        compare_all();
    endtask

    task automatic send(input logic [7:0] b, input bit rdy);
        cycle(0, 1, b, rdy, 0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, rdy, 0);
    endtask

    initial begin
        edge_n = 0; last_tick = 0;
        m_ext = 0; m_brk = 0; m_ovf = 0; m_err = 0;

        // Reset state
        cycle(1, 0, 8'h00, 0, 0);
        cycle(1, 0, 8'h00, 0, 0);
        idle(2, 1);

        // 1: make, extended make, break, extended break
        send(8'h1C, 1); idle(2, 1);
        send(8'hE0, 1); idle(1, 1); send(8'h75, 1); idle(2, 1);
        send(8'hF0, 1); send(8'h1C, 1); idle(2, 1);
        send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1); idle(3, 1);

        // 2: prefix timeout, then a normal byte
        send(8'hE0, 1); idle(TMO + 4, 1);
        send(8'h1C, 1); idle(2, 1);
        send(8'hF0, 1); idle(TMO - 2, 1); send(8'h2B, 1); idle(2, 1);

        // 3: protocol errors and tolerated repeated E0
        send(8'hF0, 1); send(8'hF0, 1); idle(2, 1);
        send(8'h00, 1); idle(2, 1);
        send(8'hFF, 1); idle(1, 1);
        send(8'hE0, 1); send(8'hE0, 1); send(8'h75, 1); idle(2, 1);
        send(8'hE0, 1); send(8'hF0, 1); send(8'hE0, 1); idle(2, 1);

        // 4: fill, overflow, drain, clear
        send(8'h1C, 0); send(8'h32, 0); send(8'h21, 0); idle(1, 0);
        send(8'hAA, 0); idle(1, 0);
        send(8'hFA, 0); idle(1, 0);
        send(8'hEE, 0); cycle(0, 0, 8'h00, 0, 1);
        idle(6, 1);
        cycle(0, 0, 8'h00, 0, 1); idle(1, 0);

        // 5: full FIFO, push and pop in the same cycle; then drop racing a clear
        send(8'h11, 0); send(8'h12, 0); send(8'h13, 0); send(8'h14, 0);
        send(8'h15, 1); idle(1, 0);
        cycle(0, 1, 8'h16, 0, 1); idle(1, 0);
        idle(5, 1); cycle(0, 0, 8'h00, 0, 1);

        // 6: reset with two events buffered and the parser mid extended-break
        send(8'h1C, 0); send(8'h32, 0); send(8'hE0, 0); send(8'hF0, 0);
        cycle(1, 0, 8'h00, 0, 0);
        idle(1, 0);
        send(8'h1C, 0); idle(1, 1); idle(1, 1);

        // Random traffic with prefix-heavy bytes, gaps long enough to time out, and resets
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] b;
            bit         tk, rdy, clr, rst;
            case ($urandom_range(0, 7))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                2:       b = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
                default: b = 8'($urandom_range(1, 254));
            endcase
            tk  = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 499) == 0);
            cycle(rst, tk, b, rdy, clr);
            if ($urandom_range(0, 99) == 0) idle(TMO + 2, 0);
        end
        idle(DEPTH + 2, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
